// File: rtl/run_sequencer.sv
// run_sequencer: sequences a downstream core through reset, a timed run and completion
module run_sequencer #(
  parameter int          RST_CYCLES = 4,
  parameter logic [15:0] TIMEOUT    = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        core_done,
  output logic        core_reset,
  output logic        core_req,
  output logic        busy,
  output logic        run_done,
  output logic        timeout,
  output logic [15:0] cycle_count
);
  typedef enum logic [1:0] {IDLE, RESET_CORE, RUN, FINISH} state_t;
  state_t state, state_nx;
  logic [7:0] hold_cnt;
  logic [15:0] cnt_inc;
  assign cnt_inc = cycle_count + 16'd1;
  assign core_reset = state != RUN;
  assign busy = state != IDLE;
  assign run_done = state == FINISH;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:       state_nx = start ? RESET_CORE : IDLE;
      RESET_CORE: state_nx = hold_cnt == 8'd1 ? RUN : RESET_CORE;
      RUN:        state_nx = (core_done || cnt_inc == TIMEOUT) ? FINISH : RUN;
      default:    state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      hold_cnt <= 8'd0;
      cycle_count <= 16'd0;
      timeout <= 1'b0;
      core_req <= 1'b0;
    end else begin
      state <= state_nx;
      core_req <= state == RESET_CORE && state_nx == RUN;
      if (state == IDLE && start) begin
        hold_cnt <= 8'(RST_CYCLES);
        cycle_count <= 16'd0;
        timeout <= 1'b0;
      end
      if (state == RESET_CORE) hold_cnt <= hold_cnt - 8'd1;
      if (state == RUN) begin
        cycle_count <= cnt_inc;
        timeout <= !core_done && cnt_inc == TIMEOUT;
      end
    end
  end
endmodule

// File: doc/run_sequencer.md
RUN_SEQUENCER -- requirements
Module: run_sequencer

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 4: cycles core_reset is held after start acceptance; legal range 1..255.
REQ-002 SHALL have parameter TIMEOUT, default 16'hFFFF: maximum RUN cycles before abort; legal range 1..65535.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  host run request, sampled each cycle.
REQ-006 SHALL have port core_done  input  1  done flag from the downstream core.
REQ-007 SHALL have port core_reset  output  1  reset to the downstream core.
REQ-008 SHALL have port core_req  output  1  one-cycle request pulse to the core.
REQ-009 SHALL have port busy  output  1  high while a run is in progress.
REQ-010 SHALL have port run_done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port timeout  output  1  sticky abort flag for the last run.
REQ-012 SHALL have port cycle_count  output  16  RUN-cycle count of the current or last run.

Function
REQ-013 SHALL implement FSM states IDLE, RESET_CORE, RUN, FINISH; all outputs registered (driven from state or registers only, no combinational path from inputs).
REQ-014 IDLE: core_reset=1, busy=0; start=1 -> RESET_CORE, reset-hold counter loaded with RST_CYCLES, cycle_count cleared to 0, timeout cleared to 0.
REQ-015 RESET_CORE: core_reset=1, busy=1; counter decrements each cycle; exactly RST_CYCLES cycles spent here, then -> RUN.
REQ-016 RUN: core_reset=0, busy=1; core_req=1 on first RUN cycle only, 0 otherwise.
REQ-017 RUN: cycle_count increments by 1 every RUN cycle, including the cycle core_done is first sampled high.
REQ-018 RUN: core_done=1 -> FINISH, timeout stays 0; core_done=1 on first RUN cycle gives final cycle_count=1.
REQ-019 RUN: when the increment makes cycle_count equal TIMEOUT and core_done=0 in that cycle -> FINISH with timeout=1; core_done=1 in the same cycle takes priority (timeout=0).
REQ-020 cycle_count SHALL never exceed TIMEOUT and never wrap.
REQ-021 FINISH: exactly one cycle; run_done=1, busy=1, core_reset=1; -> IDLE.
REQ-022 cycle_count and timeout SHALL hold their values from FINISH until the next accepted start.
REQ-023 start SHALL be ignored in RESET_CORE, RUN and FINISH; no queuing; start held high continuously re-triggers in the first IDLE cycle after FINISH.
REQ-024 core_done SHALL be ignored outside RUN.

Reset
REQ-025 reset=1 at a clock edge SHALL force state=IDLE, core_reset=1, core_req=0, busy=0, run_done=0, timeout=0, cycle_count=0, reset-hold counter=0.
REQ-026 reset SHALL take priority over start, core_done and every state transition.
REQ-027 reset in any state mid-run SHALL abort the run without a run_done pulse.

Verification
REQ-028 Nominal: RST_CYCLES=4, start pulse at cycle 0, core_done high from RUN cycle 10 -> core_reset high cycles 1-4, core_req pulse cycle 5, run_done pulse one cycle after done sampled, cycle_count=10, timeout=0.
REQ-029 Timeout: TIMEOUT=20, core_done held 0 -> cycle_count=20, timeout=1, single run_done pulse, back to IDLE.
REQ-030 Timeout/done tie: TIMEOUT=20, core_done rises on RUN cycle 20 -> cycle_count=20, timeout=0.
REQ-031 Immediate done: core_done=1 throughout -> cycle_count=1, core_req and run_done each pulse once.
REQ-032 Busy start: start pulses during RESET_CORE, RUN and FINISH -> no state change, no extra run; start held high -> new run begins in the IDLE cycle after FINISH with cycle_count cleared.
REQ-033 Mid-run reset: reset asserted at RUN cycle 5 -> next cycle all outputs at REQ-025 values, no run_done pulse; a later start runs normally.
